// File: rtl/l2_cacheline_adaptor.sv
// rtl/l2_cacheline_adaptor.sv - L2 line to memory burst adaptor (line read assembly / line write split)
module l2_cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [LINE_WIDTH-1:0]  r_buf;
  logic [ADDR_WIDTH-1:0]  r_addr;

  logic                   w_rd_start;
  logic                   w_wr_start;
  logic                   w_beat;
  logic                   w_last;
  logic                   w_read;
  logic                   w_write;
  logic                   w_resp;
  logic [ADDR_WIDTH-1:0]  w_addr_aligned;
  logic [BURST_WIDTH-1:0] w_beats [BEATS];
  logic                   w_addr_unused;

  // Offset bits inside a line never reach memory; the burst always starts at the line base.
  assign w_addr_aligned = {address_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign w_addr_unused  = ^address_i[OFF_W-1:0];
  assign w_last         = (r_cnt == CNT_W'(BEATS - 1));

  // Beat view of the line buffer; beat 0 is the least-significant slice.
  always_comb begin
    for (int i = 0; i < BEATS; i++) begin
      w_beats[i] = r_buf[i*BURST_WIDTH +: BURST_WIDTH];
    end
  end

  // Next-state and bus control; write wins over read when both are requested.
  always_comb begin
    w_state_next = r_state;
    w_rd_start   = 1'b0;
    w_wr_start   = 1'b0;
    w_beat       = 1'b0;
    w_read       = 1'b0;
    w_write      = 1'b0;
    w_resp       = 1'b0;
    case (r_state)
      IDLE: begin
        if (write_i) begin
          w_wr_start   = 1'b1;
          w_state_next = WRITE;
        end else if (read_i) begin
          w_rd_start   = 1'b1;
          w_state_next = READ;
        end
      end
      READ: begin
        w_read = 1'b1;
        w_beat = resp_i;
        if (resp_i && w_last) begin
          w_state_next = DONE;
        end
      end
      WRITE: begin
        w_write = 1'b1;
        w_beat  = resp_i;
        if (resp_i && w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_resp       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register; reset anywhere, including mid-burst, drops back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Line buffer, burst address and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf  <= '0;
      r_addr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr_start) begin
        r_buf  <= line_i;
        r_addr <= w_addr_aligned;
        r_cnt  <= '0;
      end else if (w_rd_start) begin
        r_addr <= w_addr_aligned;
        r_cnt  <= '0;
      end
      if (w_beat) begin
        if (r_state == READ) begin
          for (int i = 0; i < BEATS; i++) begin
            if (r_cnt == CNT_W'(i)) begin
              r_buf[i*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
            end
          end
        end
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign line_o    = r_buf;
  assign address_o = r_addr;
  assign read_o    = w_read;
  assign write_o   = w_write;
  assign resp_o    = w_resp;
  assign burst_o   = w_write ? w_beats[r_cnt] : '0;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// tb/tb_l2_cacheline_adaptor.sv - directed scoreboard bench for l2_cacheline_adaptor
module tb_l2_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int checks = 0;
  int errors = 0;

  logic [255:0] q_line [$];
  logic [63:0]  q_beat [$];

  l2_cacheline_adaptor #(
    .LINE_WIDTH(256),
    .BURST_WIDTH(64),
    .ADDR_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .line_i(line_i),
    .line_o(line_o),
    .address_i(address_i),
    .read_i(read_i),
    .write_i(write_i),
    .resp_o(resp_o),
    .burst_i(burst_i),
    .burst_o(burst_o),
    .address_o(address_o),
    .read_o(read_o),
    .write_o(write_o),
    .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read burst; pat bit k gives resp_i for the k-th cycle after capture.
  task automatic do_read(input logic [31:0] addr, input logic [255:0] line, input logic [63:0] pat);
    int  sent;
    int  exp_step;
    bit  done;
    logic [255:0] exp_line;
    @(negedge clk);
    check("rd_idle_resp", {255'd0, resp_o}, 256'd0);
    check("rd_idle_rw", {254'd0, read_o, write_o}, 256'd0);
    address_i = addr;
    read_i    = 1'b1;
    q_line.push_back(line);
    sent = 0;
    exp_step = 0;
    done = 1'b0;
    for (int step = 1; step <= 40 && !done; step++) begin
      @(negedge clk);
      if (resp_o) begin
        exp_line = q_line.pop_front();
        check("rd_resp_step", 256'(step), 256'(exp_step));
        check("rd_line", line_o, exp_line);
        check("rd_done_rw", {254'd0, read_o, write_o}, 256'd0);
        read_i = 1'b0;
        resp_i = 1'b0;
        done   = 1'b1;
      end else begin
        check("rd_read_o", {254'd0, read_o, write_o}, 256'd2);
        check("rd_addr", {224'd0, address_o}, {224'd0, addr[31:5], 5'd0});
        if (sent < 4 && pat[step-1]) begin
          resp_i  = 1'b1;
          burst_i = line[sent*64 +: 64];
          sent++;
          if (sent == 4) exp_step = step + 1;
        end else begin
          resp_i  = 1'b0;
          burst_i = {$urandom, $urandom};
        end
      end
    end
    if (!done) check("rd_timeout", 256'd0, 256'd1);
  endtask

  // Write burst; both=1 raises read_i alongside write_i in the request cycle.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input logic [63:0] pat,
                          input bit both);
    int  sent;
    int  exp_step;
    bit  done;
    @(negedge clk);
    check("wr_idle_resp", {255'd0, resp_o}, 256'd0);
    check("wr_idle_rw", {254'd0, read_o, write_o}, 256'd0);
    address_i = addr;
    line_i    = line;
    write_i   = 1'b1;
    read_i    = both;
    for (int i = 0; i < 4; i++) q_beat.push_back(line[i*64 +: 64]);
    sent = 0;
    exp_step = 0;
    done = 1'b0;
    for (int step = 1; step <= 40 && !done; step++) begin
      @(negedge clk);
      read_i = 1'b0;
      if (resp_o) begin
        check("wr_resp_step", 256'(step), 256'(exp_step));
        check("wr_done_rw", {254'd0, read_o, write_o}, 256'd0);
        write_i = 1'b0;
        resp_i  = 1'b0;
        done    = 1'b1;
      end else begin
        check("wr_write_o", {254'd0, read_o, write_o}, 256'd1);
        check("wr_addr", {224'd0, address_o}, {224'd0, addr[31:5], 5'd0});
        if (sent < 4 && pat[step-1]) begin
          resp_i = 1'b1;
          check("wr_beat", {192'd0, burst_o}, {192'd0, q_beat.pop_front()});
          sent++;
          if (sent == 4) exp_step = step + 1;
        end else begin
          resp_i = 1'b0;
        end
      end
    end
    if (!done) check("wr_timeout", 256'd0, 256'd1);
  endtask

  initial begin
    rst       = 1'b1;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_line_o", line_o, 256'd0);
    check("rst_address_o", {224'd0, address_o}, 256'd0);
    check("rst_burst_o", {192'd0, burst_o}, 256'd0);
    check("rst_ctrl", {253'd0, read_o, write_o, resp_o}, 256'd0);
    rst = 1'b0;

    // Plain read, consecutive beats.
    do_read(32'h1234_567F,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
            64'hF);

    // Plain write, consecutive beats.
    do_write(32'h0000_1047,
             {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
             64'hF, 1'b0);

    // Gapped read: resp_i 1,0,0,1,1,0,1.
    do_read(32'hCAFE_0010,
            {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
             64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_F0F0_1234_8765},
            64'h59);

    // Reset after two read beats aborts the burst.
    @(negedge clk);
    address_i = 32'h0000_2000;
    read_i    = 1'b1;
    @(negedge clk);
    resp_i  = 1'b1;
    burst_i = 64'h9999_9999_9999_9999;
    @(negedge clk);
    burst_i = 64'h8888_8888_8888_8888;
    @(negedge clk);
    rst    = 1'b1;
    resp_i = 1'b0;
    read_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ctrl", {253'd0, read_o, write_o, resp_o}, 256'd0);
    check("abort_line_o", line_o, 256'd0);
    @(negedge clk);
    check("abort_no_resp", {255'd0, resp_o}, 256'd0);
    do_read(32'h0000_20FF,
            {64'h1357_9BDF_2468_ACE0, 64'h7777_0000_7777_0000,
             64'h0000_FFFF_0000_FFFF, 64'hDEAD_BEEF_F00D_CAFE},
            64'hF);

    // Writeback immediately followed by refill.
    do_write(32'h0001_0000,
             {64'hA1A1_A1A1_A1A1_A1A1, 64'hB2B2_B2B2_B2B2_B2B2,
              64'hC3C3_C3C3_C3C3_C3C3, 64'hD4D4_D4D4_D4D4_D4D4},
             64'hF, 1'b0);
    do_read(32'h0002_0020,
            {64'h1010_1010_1010_1010, 64'h2020_2020_2020_2020,
             64'h3030_3030_3030_3030, 64'h4040_4040_4040_4040},
            64'hF);

    // Simultaneous read_i and write_i: write wins.
    do_write(32'h0003_0040,
             {64'hEEEE_0000_EEEE_0000, 64'h6666_1111_6666_1111,
              64'h0BAD_0BAD_0BAD_0BAD, 64'h1234_0000_0000_4321},
             64'h2D, 1'b1);

    @(negedge clk);
    check("sb_line_empty", 256'(q_line.size()), 256'd0);
    check("sb_beat_empty", 256'(q_beat.size()), 256'd0);
    check("final_idle", {253'd0, read_o, write_o, resp_o}, 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
